hamming_encode_seq: RTL and testbench
=====================================

# hamming_encode_seq

Hardware sequencer that runs the program-1 workload (Hamming SECDED encoding) over data memory without the processor core. On a `req` pulse it walks NUM_MSG 11-bit messages stored as byte pairs at SRC_BASE, computes the 16-bit SECDED codeword for each, and writes the codeword pairs to DST_BASE. It then pulses `ack`. It owns the data-memory port while busy and sits beside the core in the top level as a memory-port master.

## Interface
- NUM_MSG, 15: messages per request (1..15).
- SRC_BASE, 0: byte address of message 0 low byte.
- DST_BASE, 30: byte address of codeword 0 low byte.
- ADDR_W, 8: memory address width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- ack  out  1  one-cycle done pulse.
- busy  out  1  high from the first read state through the last write state.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_wr_en  out  1  write strobe; memory writes on the rising edge while high.
- mem_wr_data  out  8  write byte.
- mem_rd_data  in  8  combinational read data for the current mem_addr.

## Operation
- Message i in memory:
  - low byte at SRC_BASE+2i holds d[8:1].
  - high byte at SRC_BASE+2i+1 holds d[11:9] in bits [2:0]; bits [7:3] are ignored.
- Parity bits:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1] ^ p8 ^ p4 ^ p2 ^ p1
- Codeword = {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.
  - Low byte goes to DST_BASE+2i.
  - High byte goes to DST_BASE+2i+1.
- State machine, 4-bit message counter i:
  - IDLE: req=1 → RD_LO with i=0.
  - RD_LO: addr=SRC_BASE+2i; capture mem_rd_data into d[8:1]. → RD_HI.
  - RD_HI: addr=SRC_BASE+2i+1; capture mem_rd_data[2:0] into d[11:9]. → WR_LO.
  - WR_LO: addr=DST_BASE+2i; wr_en=1; data = codeword[7:0]. → WR_HI.
  - WR_HI: addr=DST_BASE+2i+1; wr_en=1; data = codeword[15:8].
    - If i==NUM_MSG-1 → DONE.
    - Otherwise i++ and → RD_LO.
  - DONE: ack=1. → IDLE.
- Parity is combinational from the captured registers, and is valid in WR_LO.
- Address arithmetic is modulo 2^ADDR_W, so addresses wrap silently.
- Address overlap between the source and destination ranges is not checked. Each message is read before its own writes.

## Timing
- Reset (async assert, any state): state=IDLE, i=0, captured data=0, ack=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - Bytes already written before reset stay in memory.
  - Release is synchronous to clock.
- In IDLE and DONE: mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- mem_addr, mem_wr_en and mem_wr_data are decoded combinationally from state and i; they are not pipelined.
- req is sampled high at edge k in IDLE:
  - RD_LO occupies cycle k..k+1.
  - Each message takes exactly 4 cycles.
  - DONE (ack high) occupies cycle 4·NUM_MSG after edge k. For NUM_MSG=15, ack is high in the 61st cycle after the sampling edge.
- ack is high for exactly one cycle. The next edge returns the block to IDLE.
  - req high on that same edge is ignored.
  - A new req is accepted from the following edge onward.
- req asserted while busy or in DONE is ignored; it is not queued.
- A held-high req restarts the run each time the block is in IDLE, so back-to-back runs are separated by one IDLE cycle.

## Test plan
- Reset mid-run:
  - Stimulus: assert reset_n=0 during WR_HI of message 3.
  - Required: all outputs 0 immediately. Messages 0-2 codewords are present in memory; message 3 high byte is not written.
  - After release, a new req gives a full correct run.
- Known vector:
  - Stimulus: core[1]=0x05, core[0]=0x55 (d=0x555).
  - Required: core[31]=0xAA, core[30]=0x5A.
- Ignored high bits:
  - Stimulus: core[1]=0xFD, core[0]=0x55.
  - Required: core[31]=0xAA, core[30]=0x5A.
- Extremes:
  - All-zero message → codeword 0x0000.
  - d=0x7FF (core[1]=0x07, core[0]=0xFF) → codeword 0xFFFF.
- Full run:
  - Stimulus: 15 random messages and a one-cycle req.
  - Required: all 15 codewords match the parity model. ack is high exactly once, in cycle 61. No writes occur outside bytes 30..59.
- Requests while busy or in DONE:
  - Stimulus: extra req pulses during a run and on the DONE cycle.
  - Required: no restart, total run length stays 61 cycles, and the memory image matches a single run.

Source files
------------

// File: rtl/hamming_encode_seq.sv
// Memory-port master that SECDED-encodes NUM_MSG 11-bit messages from SRC_BASE
// into 16-bit codewords at DST_BASE, then pulses ack for one cycle.
module hamming_encode_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [3:0]        LAST = 4'(NUM_MSG - 1);
  localparam logic [ADDR_W-1:0] SRC  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  logic [3:0]        idx;
  logic [11:1]       data;
  logic [ADDR_W-1:0] offset;
  logic              p8, p4, p2, p1, p0;
  logic [15:0]       codeword;
  logic              unused_hi;

  // Upper bits of the message high byte carry no data.
  assign unused_hi = ^mem_rd_data[7:3];

  assign offset = ADDR_W'({idx, 1'b0});

  assign p8 = ^data[11:5];
  assign p4 = (^data[11:8]) ^ (^data[4:2]);
  assign p2 = data[11] ^ data[10] ^ data[7] ^ data[6] ^ data[4] ^ data[3] ^ data[1];
  assign p1 = data[11] ^ data[9] ^ data[7] ^ data[5] ^ data[4] ^ data[2] ^ data[1];
  assign p0 = (^data) ^ p8 ^ p4 ^ p2 ^ p1;
  assign codeword = {data[11:5], p8, data[4:2], p4, data[1], p2, p1, p0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 4'd0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= RD_LO;
            idx   <= 4'd0;
          end
        end
        RD_LO: begin
          data[8:1] <= mem_rd_data;
          state     <= RD_HI;
        end
        RD_HI: begin
          data[11:9] <= mem_rd_data[2:0];
          state      <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= RD_LO;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port is decoded straight from state and idx, with no pipelining.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state)
      RD_LO: mem_addr = SRC + offset;
      RD_HI: mem_addr = SRC + offset + ONE;
      WR_LO: begin
        mem_addr    = DST + offset;
        mem_wr_en   = 1'b1;
        mem_wr_data = codeword[7:0];
      end
      WR_HI: begin
        mem_addr    = DST + offset + ONE;
        mem_wr_en   = 1'b1;
        mem_wr_data = codeword[15:8];
      end
      default: ;
    endcase
  end

  assign ack  = (state == DONE);
  assign busy = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);

endmodule

// File: tb/tb_hamming_encode_seq.sv
// Scoreboard bench for hamming_encode_seq: expected writes are queued from a
// position-based Hamming model and popped by a monitor on every write strobe.
module tb_hamming_encode_seq;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;
  localparam int ADDR_W   = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              ack, busy, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wr_data, mem_rd_data;

  logic [7:0]  mem [256];
  logic [7:0]  exp_mem [256];
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [7:0]  load_data = 8'h00;
  logic [15:0] exp_q[$];
  logic [7:0]  src_lo [NUM_MSG];
  logic [7:0]  src_hi [NUM_MSG];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  hamming_encode_seq #(
    .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .ack(ack), .busy(busy),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Single-port byte memory; the bench preloads it through a side port.
  always @(posedge clock) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    else if (load_en) mem[load_addr] <= load_data;
  end

  assign mem_rd_data = mem[mem_addr];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Data bits fill the non-power-of-two positions 3..15; parity bit at
  // position p covers every position whose index has bit p set.
  function automatic logic [15:0] model_cw(input logic [10:0] d);
    logic [15:0] cw = '0;
    int k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      logic par = 1'b0;
      for (int pos = 1; pos < 16; pos++) if ((pos & p) != 0) par ^= cw[pos];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic int wrap(input int a);
    return a % 256;
  endfunction

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge clock) begin
    logic [15:0] e;
    if (reset_n && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", int'(mem_addr), int'(e[15:8]));
        check_output("write_data", int'(mem_wr_data), int'(e[7:0]));
      end
    end
  end

  task automatic load_byte(input int a, input logic [7:0] v);
    load_addr = 8'(wrap(a));
    load_data = v;
    load_en = 1'b1;
    @(posedge clock);
    #1 load_en = 1'b0;
    exp_mem[wrap(a)] = v;
  endtask

  task automatic randomize_src();
    for (int i = 0; i < NUM_MSG; i++) begin
      src_lo[i] = 8'($urandom);
      src_hi[i] = 8'($urandom);
    end
  endtask

  // Loads the sources and queues the expected writes of the first n_bytes bytes.
  task automatic prepare(input int n_bytes, input bit update_image);
    logic [15:0] cw;
    for (int i = 0; i < NUM_MSG; i++) begin
      load_byte(SRC_BASE + 2 * i, src_lo[i]);
      load_byte(SRC_BASE + 2 * i + 1, src_hi[i]);
    end
    for (int b = 0; b < n_bytes; b++) begin
      cw = model_cw({src_hi[b / 2][2:0], src_lo[b / 2]});
      exp_q.push_back({8'(wrap(DST_BASE + b)), (b % 2 == 0) ? cw[7:0] : cw[15:8]});
      if (update_image) exp_mem[wrap(DST_BASE + b)] = (b % 2 == 0) ? cw[7:0] : cw[15:8];
    end
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_output(name, bad, 0);
  endtask

  task automatic apply_stimulus(input bit extra_reqs, input bit req_on_done);
    int n = 0, acks = 0, ack_at = 0, busy_n = 0;
    prepare(2 * NUM_MSG, 1'b1);
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    while (n < 66) begin
      @(negedge clock);
      n++;
      if (ack) begin
        acks++;
        if (ack_at == 0) ack_at = n;
      end
      if (busy) busy_n++;
      req = 1'b0;
      if (extra_reqs && n < 60 && $urandom_range(0, 3) == 0) req = 1'b1;
      if (req_on_done && ack) req = 1'b1;
    end
    req = 1'b0;
    check_output("ack_count", acks, 1);
    check_output("ack_cycle", ack_at, 4 * NUM_MSG + 1);
    check_output("busy_cycles", busy_n, 4 * NUM_MSG);
    check_output("queue_drained", exp_q.size(), 0);
    check_image("memory_image");
  endtask

  task automatic reset_mid_run();
    logic [15:0] cw3;
    bit found = 1'b0;
    randomize_src();
    cw3 = model_cw({src_hi[3][2:0], src_lo[3]});
    load_byte(DST_BASE + 7, ~cw3[15:8]);
    prepare(8, 1'b0);
    for (int b = 0; b < 7; b++) begin
      cw3 = model_cw({src_hi[b / 2][2:0], src_lo[b / 2]});
      exp_mem[DST_BASE + b] = (b % 2 == 0) ? cw3[7:0] : cw3[15:8];
    end
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clock);
      if (mem_wr_en && int'(mem_addr) == DST_BASE + 7) found = 1'b1;
    end
    check_output("reset_wait_found", int'(found), 1);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_reset_ack", int'(ack), 0);
    check_output("mid_reset_busy", int'(busy), 0);
    check_output("mid_reset_wr_en", int'(mem_wr_en), 0);
    check_output("mid_reset_addr", int'(mem_addr), 0);
    check_output("mid_reset_wr_data", int'(mem_wr_data), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_output("mid_reset_queue", exp_q.size(), 0);
    check_image("mid_reset_image");
  endtask

  task automatic held_req();
    int n = 0, acks = 0, first = 0, second = 0;
    randomize_src();
    prepare(2 * NUM_MSG, 1'b1);
    prepare(2 * NUM_MSG, 1'b1);
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    while (n < 140 && acks < 2) begin
      @(negedge clock);
      n++;
      if (ack) begin
        acks++;
        if (acks == 1) first = n;
        else second = n;
      end
    end
    req = 1'b0;
    repeat (4) @(negedge clock);
    check_output("held_first_ack", first, 4 * NUM_MSG + 1);
    check_output("held_second_ack", second, 2 * (4 * NUM_MSG + 1) + 1);
    check_output("held_busy_after", int'(busy), 0);
    check_output("held_queue", exp_q.size(), 0);
    check_image("held_image");
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_output("reset_ack", int'(ack), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_wr_en", int'(mem_wr_en), 0);
    check_output("reset_addr", int'(mem_addr), 0);
    check_output("reset_wr_data", int'(mem_wr_data), 0);
    reset_n = 1'b1;
    for (int a = 0; a < 256; a++) load_byte(a, 8'h00);

    randomize_src();
    src_lo[0] = 8'h55;
    src_hi[0] = 8'h05;
    apply_stimulus(1'b0, 1'b0);
    check_output("known_vector_lo", int'(mem[30]), 8'h5A);
    check_output("known_vector_hi", int'(mem[31]), 8'hAA);

    src_hi[0] = 8'hFD;
    apply_stimulus(1'b0, 1'b0);
    check_output("ignored_bits_lo", int'(mem[30]), 8'h5A);
    check_output("ignored_bits_hi", int'(mem[31]), 8'hAA);

    randomize_src();
    src_lo[0] = 8'h00;
    src_hi[0] = 8'h00;
    src_lo[1] = 8'hFF;
    src_hi[1] = 8'h07;
    apply_stimulus(1'b0, 1'b0);
    check_output("zero_msg_cw", int'({mem[31], mem[30]}), 16'h0000);
    check_output("ones_msg_cw", int'({mem[33], mem[32]}), 16'hFFFF);

    for (int r = 0; r < 3; r++) begin
      randomize_src();
      apply_stimulus(r != 0, r == 2);
    end

    reset_mid_run();
    randomize_src();
    apply_stimulus(1'b0, 1'b0);

    held_req();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
